// File: rtl/row_pkg.sv
// Shared types and sizing helpers for the row event encoder.
package row_pkg;

  localparam int unsigned PAIR_ROW_NO_DEF = 64;

  function automatic int unsigned row_idx_w(input int unsigned rows);
    return $clog2(rows);
  endfunction

  localparam int unsigned ROW_IDX_W = $clog2(PAIR_ROW_NO_DEF);

  typedef logic [ROW_IDX_W-1:0] row_idx_t;

  typedef enum logic {SLOT_EMPTY, SLOT_FULL} slot_st_t;

endpackage

// File: rtl/rr_prio_enc.sv
// Round-robin priority encoder: first set request at index >= ptr, wrapping to 0.
module rr_prio_enc #(
  parameter int unsigned N = 64,
  localparam int unsigned W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         gnt_valid,
  output logic [W-1:0] gnt_idx
);

  logic [N-1:0]   masked;
  logic [2*N-1:0] dbl;

  always_comb begin
    masked    = req & ({N{1'b1}} << ptr);
    // Masked copy in the low half wins; full copy in the high half supplies the wrap.
    dbl       = {req, masked};
    gnt_valid = |req;
    gnt_idx   = '0;
    for (int i = 2 * N - 1; i >= 0; i--) begin
      if (dbl[i]) gnt_idx = W'(i);
    end
  end

endmodule

// File: rtl/row_evt_enc.sv
// Row event encoder: coalesces multi-hot row events and streams binary row indices.
// Optional saturating drop counter enabled by defining ROW_EVT_DROP_CNT_EN.
module row_evt_enc
  import row_pkg::*;
#(
  parameter int unsigned PAIR_ROW_NO = 64,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           en,
  input  logic                           clr,
  input  logic [PAIR_ROW_NO-1:0]         evt_in,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [$clog2(PAIR_ROW_NO)-1:0] out_idx,
  output logic                           busy
`ifdef ROW_EVT_DROP_CNT_EN
  ,
  output logic [CNT_W-1:0]               drop_cnt
`endif
);

  localparam int unsigned IdxW = row_idx_w(PAIR_ROW_NO);

  if (PAIR_ROW_NO < 2 || (PAIR_ROW_NO & (PAIR_ROW_NO - 1)) != 0) begin : g_bad_rows
    $error("PAIR_ROW_NO must be a power of 2 and >= 2");
  end
  if (CNT_W < 1 || CNT_W > 31) begin : g_bad_cnt_w
    $error("CNT_W must be in 1..31");
  end

  logic [PAIR_ROW_NO-1:0] pending_q, pending_d;
  slot_st_t               slot_q, slot_d;
  logic [IdxW-1:0]        idx_q, idx_d;
  logic [IdxW-1:0]        ptr_q, ptr_d;
  logic                   gnt_valid;
  logic [IdxW-1:0]        gnt_idx;
  logic                   load;
  logic [PAIR_ROW_NO-1:0] load_vec;

  rr_prio_enc #(
    .N (PAIR_ROW_NO)
  ) u_rr_prio_enc (
    .req       (pending_q),
    .ptr       (ptr_q),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  always_comb begin
    load     = 1'b0;
    load_vec = '0;
    slot_d   = slot_q;
    idx_d    = idx_q;
    ptr_d    = ptr_q;

    if (!clr && gnt_valid && (slot_q == SLOT_EMPTY || out_ready)) load = 1'b1;
    if (load) load_vec[gnt_idx] = 1'b1;

    // New events are ORed after the load clear so a same-row refire is never lost.
    pending_d = (pending_q & ~load_vec) | ({PAIR_ROW_NO{en}} & evt_in);

    unique case (slot_q)
      SLOT_EMPTY: if (load) slot_d = SLOT_FULL;
      SLOT_FULL:  if (out_ready && !load) slot_d = SLOT_EMPTY;
      default:    slot_d = SLOT_EMPTY;
    endcase

    if (load) begin
      idx_d = gnt_idx;
      ptr_d = gnt_idx + IdxW'(1);
    end

    if (clr) begin
      pending_d = '0;
      slot_d    = SLOT_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      slot_q    <= SLOT_EMPTY;
      idx_q     <= '0;
      ptr_q     <= '0;
    end else begin
      pending_q <= pending_d;
      slot_q    <= slot_d;
      idx_q     <= idx_d;
      ptr_q     <= ptr_d;
    end
  end

  assign out_valid = (slot_q == SLOT_FULL);
  assign out_idx   = idx_q;
  assign busy      = (|pending_q) | out_valid;

`ifdef ROW_EVT_DROP_CNT_EN
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [PAIR_ROW_NO-1:0]  drop_vec;
  logic [IdxW:0]           drop_pop;
  logic [CNT_W+IdxW:0]     cnt_sum;

  always_comb begin
    drop_vec = clr ? '0 : ({PAIR_ROW_NO{en}} & evt_in & pending_q & ~load_vec);
    drop_pop = '0;
    for (int k = 0; k < PAIR_ROW_NO; k++) begin
      drop_pop = drop_pop + (IdxW + 1)'(drop_vec[k]);
    end
    cnt_sum = (CNT_W + IdxW + 1)'(cnt_q) + (CNT_W + IdxW + 1)'(drop_pop);
    if (cnt_sum > (CNT_W + IdxW + 1)'({CNT_W{1'b1}})) begin
      cnt_d = {CNT_W{1'b1}};
    end else begin
      cnt_d = cnt_sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign drop_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_row_evt_enc.sv
// Randomised and directed bench for row_evt_enc against a row-array reference model.
module tb_row_evt_enc;

  localparam int N  = 64;
  localparam int W  = 6;
  localparam int CW = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic         clr = 1'b0;
  logic [N-1:0] evt_in = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_idx;
  logic         busy;
`ifdef ROW_EVT_DROP_CNT_EN
  logic [CW-1:0] drop_cnt;
`endif

  always #5 clk = ~clk;

  row_evt_enc #(
    .PAIR_ROW_NO (N),
    .CNT_W       (CW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .clr       (clr),
    .evt_in    (evt_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .busy      (busy)
`ifdef ROW_EVT_DROP_CNT_EN
    ,
    .drop_cnt  (drop_cnt)
`endif
  );

  // Reference model state
  bit     m_pend[N];
  bit     m_valid;
  int     m_idx;
  int     m_ptr;
  longint m_drop;

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    foreach (m_pend[k]) m_pend[k] = 1'b0;
    m_valid = 1'b0;
    m_idx   = 0;
    m_ptr   = 0;
    m_drop  = 0;
  endtask

  function automatic bit model_busy();
    bit any = m_valid;
    foreach (m_pend[k]) any |= m_pend[k];
    return any;
  endfunction

  task automatic compare_all(input string tag);
    check_eq({tag, "_valid"}, 64'(out_valid), 64'(m_valid));
    check_eq({tag, "_idx"}, 64'(out_idx), 64'(m_idx));
    check_eq({tag, "_busy"}, 64'(busy), 64'(model_busy()));
`ifdef ROW_EVT_DROP_CNT_EN
    check_eq({tag, "_drop"}, 64'(drop_cnt), 64'(m_drop));
`endif
  endtask

  // One clock: evaluate the rules on current inputs, advance, compare.
  task automatic step(input string tag);
    bit     nxt[N];
    int     w = -1;
    bit     load;
    longint drops = 0;
    for (int i = 0; i < N; i++) begin
      int r = (m_ptr + i) % N;
      if (w < 0 && m_pend[r]) w = r;
    end
    load = !clr && (w >= 0) && (!m_valid || out_ready);
    for (int k = 0; k < N; k++) begin
      bit kept = m_pend[k] && !(load && k == w);
      bit hit  = en && evt_in[k];
      if (hit && kept && !clr) drops++;
      nxt[k] = clr ? 1'b0 : (kept || hit);
    end
    @(posedge clk);
    #1;
    m_pend = nxt;
    if (clr)               m_valid = 1'b0;
    else if (load)         m_valid = 1'b1;
    else if (out_ready)    m_valid = 1'b0;
    if (load) begin
      m_idx = w;
      m_ptr = (w + 1) % N;
    end
    m_drop = m_drop + drops;
    if (m_drop > 65535) m_drop = 65535;
    compare_all(tag);
  endtask

  task automatic pulse(input logic [N-1:0] v, input string tag);
    evt_in = v;
    step(tag);
    evt_in = '0;
  endtask

  task automatic expect_out(input string tag, input int idx);
    step(tag);
    check_eq({tag, "_dv"}, 64'(out_valid), 64'(1));
    check_eq({tag, "_di"}, 64'(out_idx), 64'(idx));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  logic [N-1:0] v;
  longint       drop_base;

  initial begin
    en = 1'b1;
    model_reset();
    #1;
    compare_all("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single event: visible one edge after sampling
    v = '0; v[5] = 1'b1;
    pulse(v, "t1_sample");
    check_eq("t1_not_yet", 64'(out_valid), 64'(0));
    expect_out("t1_out", 5);
    step("t1_drain");
    check_eq("t1_empty", 64'(out_valid), 64'(0));

    // Multi-hot from pointer 0
    do_reset();
    v = '0; v[3] = 1'b1; v[40] = 1'b1; v[63] = 1'b1;
    pulse(v, "t2_sample");
    expect_out("t2_a", 3);
    expect_out("t2_b", 40);
    expect_out("t2_c", 63);
    step("t2_drain");
    v = '0; v[2] = 1'b1; v[60] = 1'b1;
    pulse(v, "t2_ptr0");
    expect_out("t2_wrap0", 2);
    expect_out("t2_wrap1", 60);
    step("t2_drain2");

    // Round robin after emitting 9
    v = '0; v[9] = 1'b1;
    pulse(v, "t4_pre");
    expect_out("t4_nine", 9);
    step("t4_gap");
    v = '0; v[2] = 1'b1; v[12] = 1'b1;
    pulse(v, "t4_sample");
    expect_out("t4_first", 12);
    expect_out("t4_second", 2);
    step("t4_drain");

    // Wrap after emitting 61
    v = '0; v[61] = 1'b1;
    pulse(v, "t5_pre");
    expect_out("t5_61", 61);
    step("t5_gap");
    v = '0; v[62] = 1'b1; v[1] = 1'b1;
    pulse(v, "t5_sample");
    expect_out("t5_first", 62);
    expect_out("t5_second", 1);
    step("t5_drain");

    // Backpressure with coalescing refires of the held row
    drop_base = m_drop;
    out_ready = 1'b0;
    v = '0; v[7] = 1'b1;
    pulse(v, "t3_sample");
    expect_out("t3_load", 7);
    for (int c = 0; c < 10; c++) begin
      if (c == 2 || c == 5) evt_in = v;
      expect_out("t3_hold", 7);
      evt_in = '0;
    end
    out_ready = 1'b1;
    expect_out("t3_again", 7);
    step("t3_drain");
    check_eq("t3_once", 64'(out_valid), 64'(0));
`ifdef ROW_EVT_DROP_CNT_EN
    check_eq("t3_drop", 64'(drop_cnt) - 64'(drop_base), 64'(1));
`endif

    // clr mid-stream
    v = 64'h0101_0101_0101_0101;
    pulse(v, "t6_sample");
    for (int c = 0; c < 3; c++) step("t6_acc");
    clr = 1'b1;
    step("t6_clr");
    clr = 1'b0;
    check_eq("t6_clr_valid", 64'(out_valid), 64'(0));
    check_eq("t6_clr_busy", 64'(busy), 64'(0));

    // Async reset mid-cycle
    pulse(v, "t6r_sample");
    for (int c = 0; c < 3; c++) step("t6r_acc");
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_eq("t6r_async_valid", 64'(out_valid), 64'(0));
    check_eq("t6r_async_busy", 64'(busy), 64'(0));
    compare_all("t6r_async");
    @(posedge clk);
    #1;
    compare_all("t6r_held");
    rst_n = 1'b1;

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      en        = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      clr       = ($urandom % 150) == 0;
      v         = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
      evt_in    = (($urandom % 3) == 0) ? v : '0;
      step("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
